rr_index_arbiter: RTL and testbench
===================================

Name: rr_index_arbiter

Overview:
- Round-robin arbiter that sits directly upstream of the 3-to-8 one-hot decoder.
- It accepts up to 8 request lines and selects one requester fairly.
- It presents the winner as a registered binary index with a valid/ack handshake, so the decoder can drive the one-hot select.
- A watchdog revokes a grant that is never acknowledged.

Parameters:
- N_REQ, 8, number of request lines; must be a power of two, at least 2.
- IDX_W, $clog2(N_REQ) = 3, width of the index; derived, never overridden.
- TIMEOUT, 16, cycles a grant may wait for ack before revocation; 0 disables the watchdog.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  reset: synchronous, active-low.
- req  input  N_REQ  request lines; bit i high means requester i wants service.
- ack  input  1  downstream consumed the current index; meaningful only while grant_valid=1.
- grant_idx  output  IDX_W  registered index of the granted requester; feeds the decoder select.
- grant_valid  output  1  grant_idx is valid and held stable.
- timeout_pulse  output  1  one-cycle pulse when a grant is revoked by the watchdog.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - grant_idx=0, grant_valid=0, timeout_pulse=0.
  - Priority pointer ptr=0, wait counter=0, state=IDLE.
  - Reset overrides everything, including mid-grant; no ack is required afterwards.
- Selection function: the first i with req[i]=1, searching ptr, ptr+1, ..., ptr+N_REQ-1 modulo N_REQ (wrap-around). The result is combinational; only registered outputs leave the block.
- State IDLE:
  - grant_valid=0.
  - If req is non-zero: load grant_idx with the selection, set grant_valid=1, clear the counter, go to GRANT.
  - Latency from req to grant_valid is 1 cycle.
- State GRANT:
  - grant_idx and grant_valid are held stable.
  - Dropping req of the granted index does not revoke the grant (the grant is sticky).
  - New requests do not pre-empt the current grant.
- ack in GRANT:
  - ptr <= grant_idx+1 (mod N_REQ); the served requester becomes lowest priority.
  - If req is non-zero in the same cycle, grant again back-to-back using the new ptr: grant_valid stays 1 and grant_idx updates next cycle; stay in GRANT.
  - Otherwise grant_valid <= 0 and go to IDLE.
- Watchdog (TIMEOUT>0):
  - The counter increments every GRANT cycle without ack.
  - When counter = TIMEOUT-1 and ack=0: revoke the grant (grant_valid <= 0), pulse timeout_pulse for exactly 1 cycle, set ptr <= grant_idx+1, go to IDLE.
  - ack in the same cycle as expiry wins: normal ack path, no pulse.
- ack while grant_valid=0 is ignored.
- timeout_pulse is 0 in every cycle except the one following a revocation.
- Width rules:
  - Pointer and index arithmetic is modulo N_REQ by natural IDX_W-bit wrap; no explicit compare is needed.
  - The counter is $clog2(TIMEOUT+1) bits wide and never overflows.
- Fairness guarantee: with all requests held high, grants cycle 0,1,...,N_REQ-1,0 with one grant per ack.

Decomposition:
- Shared package arb_pkg holds:
  - the state enum (IDLE, GRANT);
  - the default constant values for N_REQ and TIMEOUT;
  - the function rr_select(req, ptr), which returns the index plus a found flag.
- One sub-module is natural: rr_prio_select, the combinational rotate / priority-encode / un-rotate wrapper around rr_select. It is reused by later arbiters.
- The FSM, pointer and watchdog stay in rr_index_arbiter.

Test Plan:
- Reset then req=8'b0000_0000 for 5 cycles -> grant_valid=0, grant_idx=0, timeout_pulse=0 throughout.
- req=8'b0010_0100 from reset, ack one cycle after each grant -> grant_idx=2, then 5, then 2; ptr wraps and grant_valid stays 1 back-to-back.
- req=8'hFF held, ack every cycle while valid -> grant_idx sequence 0,1,2,...,7,0,1 with no gaps after the first grant.
- req=8'b1000_0000 for one cycle then 0, no ack, TIMEOUT=16 -> grant_idx=7 valid for 16 cycles, then grant_valid=0 and timeout_pulse=1 for exactly one cycle; a later req=8'b1000_0001 grants index 0.
- ack asserted in the exact expiry cycle -> no timeout_pulse; normal ptr advance.
- rst_n=0 for one edge during GRANT with idx=5 -> next cycle grant_valid=0 and grant_idx=0; with req=8'b0010_0001 the first grant is index 0 (ptr reset).

Source files
------------

// File: rtl/arb_pkg.sv
// Shared arbiter definitions: FSM states, default sizing and the wrap-around
// round-robin selection function used by the index arbiters.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int N_REQ_DEF   = 8;
  localparam int TIMEOUT_DEF = 16;

  // The selector works on a fixed 32-wide view so any power-of-two arbiter up
  // to 32 requesters can share it; callers zero-extend and truncate.
  localparam int SEL_MAX = 32;
  localparam int SEL_W   = 5;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } rr_sel_t;

  // First set bit at or after ptr, wrapping modulo n (n a power of two).
  // Walk offsets from high to low so the smallest matching offset wins.
  function automatic rr_sel_t rr_select(input logic [SEL_MAX-1:0] req,
                                        input logic [SEL_W-1:0]   ptr,
                                        input int                 n);
    rr_sel_t          r;
    logic [SEL_W-1:0] pos;
    logic [SEL_W-1:0] mask;
    r    = '0;
    mask = SEL_W'(n - 1);
    for (int off = SEL_MAX - 1; off >= 0; off--) begin
      pos = (ptr + SEL_W'(off)) & mask;
      if (off < n && req[pos]) begin
        r.found = 1'b1;
        r.idx   = pos;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_prio_select.sv
// Combinational round-robin priority select: index of the first active request
// starting at ptr, wrapping around.
module rr_prio_select
  import arb_pkg::*;
#(
  parameter  int N_REQ = N_REQ_DEF,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  rr_sel_t sel;

  always_comb begin
    sel   = rr_select(SEL_MAX'(req), SEL_W'(ptr), N_REQ);
    found = sel.found;
    idx   = sel.idx[IDX_W-1:0];
  end

endmodule

// File: rtl/rr_index_arbiter.sv
// Round-robin arbiter presenting the winner as a registered binary index with a
// valid/ack handshake, plus a watchdog that revokes unacknowledged grants.
module rr_index_arbiter
  import arb_pkg::*;
#(
  parameter  int N_REQ   = N_REQ_DEF,
  parameter  int TIMEOUT = TIMEOUT_DEF,
  localparam int IDX_W   = $clog2(N_REQ),
  localparam int CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             ack,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             timeout_pulse,
  output logic             state_dbg
);

  // Handshake: grant_idx is held stable while grant_valid=1; a transfer
  // completes on a rising edge where grant_valid=1 and ack=1. ack is ignored
  // while grant_valid=0.

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_d;
  logic             valid_d;
  logic             pulse_d;

  logic [IDX_W-1:0] next_ptr;
  logic [IDX_W-1:0] sel_ptr;
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;

  assign next_ptr = grant_idx + IDX_W'(1);
  // In GRANT the selector is only consulted on ack, where the served index
  // must already be lowest priority for the back-to-back grant.
  assign sel_ptr  = (state_q == GRANT) ? next_ptr : ptr_q;

  rr_prio_select #(.N_REQ(N_REQ)) u_sel (
    .req   (req),
    .ptr   (sel_ptr),
    .found (sel_found),
    .idx   (sel_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    idx_d   = grant_idx;
    valid_d = grant_valid;
    pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (sel_found) begin
          idx_d   = sel_idx;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (ack) begin
          ptr_d = next_ptr;
          cnt_d = '0;
          if (sel_found) begin
            idx_d = sel_idx;
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end else if (TIMEOUT > 0 && cnt_q == CNT_W'(TIMEOUT - 1)) begin
          ptr_d   = next_ptr;
          valid_d = 1'b0;
          pulse_d = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (TIMEOUT > 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      cnt_q         <= '0;
      grant_idx     <= '0;
      grant_valid   <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      grant_idx     <= idx_d;
      grant_valid   <= valid_d;
      timeout_pulse <= pulse_d;
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_rr_index_arbiter.sv
// Directed bench for rr_index_arbiter: hand-computed grant sequences, watchdog
// expiry, ack-at-expiry and reset during a grant.
module tb_rr_index_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       ack;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout_pulse;
  logic       state_dbg;

  int checks;
  int errors;

  rr_index_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .ack           (ack),
    .grant_idx     (grant_idx),
    .grant_valid   (grant_valid),
    .timeout_pulse (timeout_pulse),
    .state_dbg     (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: advance one edge, settle past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [2:0] idx,
                            input logic p);
    check({tag, ".valid"}, 32'(grant_valid), 32'(v));
    check({tag, ".idx"}, 32'(grant_idx), 32'(idx));
    check({tag, ".pulse"}, 32'(timeout_pulse), 32'(p));
  endtask

  logic [2:0] exp_q[$];

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    req    = 8'h00;
    ack    = 1'b0;
    tick();
    tick();
    expect_out("reset", 1'b0, 3'd0, 1'b0);
    check("reset.state", 32'(state_dbg), 32'd0);
    rst_n = 1'b1;

    // idle with no requests
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_out($sformatf("idle%0d", i), 1'b0, 3'd0, 1'b0);
    end

    // sparse requests, ack after each grant: 2, 5, 2
    req = 8'b0010_0100;
    tick();
    expect_out("sparse0", 1'b1, 3'd2, 1'b0);
    check("sparse0.state", 32'(state_dbg), 32'd1);
    tick();
    expect_out("sparse_hold", 1'b1, 3'd2, 1'b0);
    ack = 1'b1;
    tick();
    expect_out("sparse1", 1'b1, 3'd5, 1'b0);
    tick();
    expect_out("sparse2", 1'b1, 3'd2, 1'b0);
    req = 8'h00;
    tick();
    expect_out("sparse_done", 1'b0, 3'd2, 1'b0);
    ack = 1'b0;

    // reset, then ack while idle must not move the pointer
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ack = 1'b1;
    tick();
    check("idle_ack.valid", 32'(grant_valid), 32'd0);
    ack = 1'b0;

    // all requests held: 0,1,...,7,0,1 back-to-back
    req = 8'hFF;
    tick();
    expect_out("fair_first", 1'b1, 3'd0, 1'b0);
    for (int i = 1; i <= 9; i++) exp_q.push_back(3'(i % 8));
    ack = 1'b1;
    while (exp_q.size() > 0) begin
      tick();
      expect_out("fair", 1'b1, exp_q.pop_front(), 1'b0);
    end
    req = 8'h00;
    tick();
    check("fair_done.valid", 32'(grant_valid), 32'd0);
    ack = 1'b0;

    // watchdog expiry
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req = 8'b1000_0000;
    tick();
    expect_out("wd_grant", 1'b1, 3'd7, 1'b0);
    req = 8'h00;
    for (int i = 1; i < 16; i++) begin
      tick();
      expect_out($sformatf("wd_wait%0d", i), 1'b1, 3'd7, 1'b0);
    end
    tick();
    check("wd_expire.valid", 32'(grant_valid), 32'd0);
    check("wd_expire.pulse", 32'(timeout_pulse), 32'd1);
    tick();
    check("wd_after.pulse", 32'(timeout_pulse), 32'd0);
    check("wd_after.valid", 32'(grant_valid), 32'd0);
    req = 8'b1000_0001;
    tick();
    expect_out("wd_regrant", 1'b1, 3'd0, 1'b0);
    req = 8'h00;
    ack = 1'b1;
    tick();
    check("wd_release.valid", 32'(grant_valid), 32'd0);
    ack = 1'b0;

    // ack in the exact expiry cycle wins (ptr now 1)
    req = 8'b0000_1000;
    tick();
    expect_out("race_grant", 1'b1, 3'd3, 1'b0);
    req = 8'h00;
    for (int i = 1; i < 16; i++) tick();
    expect_out("race_last", 1'b1, 3'd3, 1'b0);
    ack = 1'b1;
    req = 8'b0000_1001;
    tick();
    expect_out("race_ack", 1'b1, 3'd0, 1'b0);
    req = 8'h00;
    tick();
    expect_out("race_done", 1'b0, 3'd0, 1'b0);
    ack = 1'b0;

    // reset mid-grant on index 5 (ptr now 1)
    req = 8'b0010_0000;
    tick();
    expect_out("rst_grant", 1'b1, 3'd5, 1'b0);
    rst_n = 1'b0;
    req = 8'b0010_0001;
    tick();
    expect_out("rst_mid", 1'b0, 3'd0, 1'b0);
    rst_n = 1'b1;
    tick();
    expect_out("rst_regrant", 1'b1, 3'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
